// File: rtl/debounce_edge.sv
// -----------------------------------------------------------------------------
// debounce_edge
//   Conditions WIDTH slow, noisy external inputs (for example PS/2 clock and
//   data pins). Each channel passes through an optional 2-flop synchronizer,
//   then a per-bit counter debouncer, then an edge detector. All channels are
//   independent, so one instance serves a whole pin group.
//
// Parameters
//   WIDTH        number of independent input channels
//   CYCLES       consecutive differing samples needed to accept a new level (>=1)
//   RESET_LEVEL  level of bit_out, synchronizer and history flops after reset
//
// Ports
//   clk        in   1      single clock, all logic on posedge
//   reset      in   1      synchronous, active-high reset
//   bit_in     in   WIDTH  raw input levels
//   bit_out    out  WIDTH  debounced stable level (registered)
//   pos_edge   out  WIDTH  one-cycle pulse in the first cycle bit_out reads 1
//   neg_edge   out  WIDTH  one-cycle pulse in the first cycle bit_out reads 0
//
// Configuration
//   DEBOUNCE_SYNC_EN  when defined, a 2-flop synchronizer (reset to RESET_LEVEL)
//                     sits ahead of the debouncer and adds exactly 2 cycles of
//                     latency. When undefined, the debouncer samples bit_in
//                     directly and the caller must supply synchronous inputs.
// -----------------------------------------------------------------------------
module debounce_edge #(
    parameter int WIDTH       = 2,
    parameter int CYCLES      = 255,
    parameter bit RESET_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bit_in,
    output logic [WIDTH-1:0] bit_out,
    output logic [WIDTH-1:0] pos_edge,
    output logic [WIDTH-1:0] neg_edge
);

    // Wide enough to hold CYCLES-1; the counter never goes past that value.
    localparam int             CNT_W    = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE     = {WIDTH{RESET_LEVEL}};

    logic [WIDTH-1:0] sample;              // level seen by the debouncer
    logic [WIDTH-1:0] prev;                // bit_out one cycle ago
    logic [CNT_W-1:0] cnt [WIDTH];         // run length of disagreeing samples

`ifdef DEBOUNCE_SYNC_EN
    // -------------------------------------------------------------------------
    // Two-flop synchronizer. Reset to the idle level so that leaving reset
    // never looks like an input transition.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;

    always_ff @(posedge clk) begin
        // NOTE: every register here uses non-blocking assignment so that
        // sync_q2 captures the old sync_q1, not the value written this edge.
        if (reset) begin
            sync_q1 <= IDLE;
            sync_q2 <= IDLE;
        end else begin
            sync_q1 <= bit_in;
            sync_q2 <= sync_q1;
        end
    end

    assign sample = sync_q2;
`else
    assign sample = bit_in;
`endif

    // -------------------------------------------------------------------------
    // Debouncer and edge history.
    //   sample == bit_out : any agreeing sample restarts the count
    //   disagree, not yet CYCLES in a row : count up
    //   disagree for the CYCLES-th time   : accept the new level, clear count
    // With CYCLES=1 CNT_LAST is 0, so bit_out simply follows sample by a cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_out <= IDLE;
            prev    <= IDLE;
            // NOTE: the counter array is a handful of flops, not a RAM, so it
            // is cleared on reset; otherwise a partial count from before reset
            // could complete early afterwards.
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            prev <= bit_out;
            for (int i = 0; i < WIDTH; i++) begin
                if (sample[i] == bit_out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    bit_out[i] <= sample[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Both terms come straight from registers; since prev and bit_out agree
    // after reset, reset itself never produces a pulse.
    assign pos_edge = bit_out & ~prev;
    assign neg_edge = ~bit_out & prev;

endmodule

// File: tb/tb_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge
//   Self-checking bench for debounce_edge with CYCLES=4, WIDTH=2,
//   RESET_LEVEL=1. Directed scenarios followed by random input activity with
//   occasional resets. Every cycle the outputs are compared against a model
//   built from the accept rule: a level is taken when the last CYCLES samples
//   all differ from the current output.
// -----------------------------------------------------------------------------
module tb_debounce_edge;

    localparam int WIDTH  = 2;
    localparam int CYCLES = 4;
    localparam bit RL     = 1'b1;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int ACC = CYCLES + LAT;   // posedges from input change to new bit_out

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] bit_in;
    logic [WIDTH-1:0] bit_out;
    logic [WIDTH-1:0] pos_edge;
    logic [WIDTH-1:0] neg_edge;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] m_prev;
    logic [WIDTH-1:0] raw_q [$];          // input pipeline (synchronizer delay)
    bit               hist  [WIDTH][$];   // most recent debouncer samples per bit

    debounce_edge #(
        .WIDTH      (WIDTH),
        .CYCLES     (CYCLES),
        .RESET_LEVEL(RL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bit_in  (bit_in),
        .bit_out (bit_out),
        .pos_edge(pos_edge),
        .neg_edge(neg_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance the model by one posedge using the values the DUT just sampled.
    task automatic model_edge();
        logic [WIDTH-1:0] s;
        bit               all_diff;
        if (reset) begin
            m_out  = {WIDTH{RL}};
            m_prev = {WIDTH{RL}};
            raw_q.delete();
            repeat (LAT) raw_q.push_back({WIDTH{RL}});
            for (int i = 0; i < WIDTH; i++) hist[i].delete();
        end else begin
            m_prev = m_out;
            raw_q.push_back(bit_in);
            s = raw_q.pop_front();
            for (int i = 0; i < WIDTH; i++) begin
                hist[i].push_back(s[i]);
                if (hist[i].size() > CYCLES) void'(hist[i].pop_front());
                if (hist[i].size() == CYCLES) begin
                    all_diff = 1'b1;
                    foreach (hist[i][k]) if (hist[i][k] == m_out[i]) all_diff = 1'b0;
                    if (all_diff) m_out[i] = ~m_out[i];
                end
            end
        end
    endtask

    // One clock: update the model at the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_bit_out", bit_out, m_out);
        check("model_pos_edge", pos_edge, m_out & ~m_prev);
        check("model_neg_edge", neg_edge, ~m_out & m_prev);
        check("edge_exclusive", pos_edge & neg_edge, '0);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int pos_cnt;
        int neg_cnt;

        reset  = 1'b1;
        bit_in = 2'b00;

        // 1: reset held 3 cycles with inputs low, then the low level is accepted
        steps(3);
        check("rst_bit_out", bit_out, 2'b11);
        check("rst_pos_edge", pos_edge, 2'b00);
        check("rst_neg_edge", neg_edge, 2'b00);
        reset = 1'b0;
        for (int k = 1; k < ACC; k++) begin
            step();
            check("s1_hold", bit_out, 2'b11);
            check("s1_no_neg", neg_edge, 2'b00);
        end
        step();
        check("s1_fall", bit_out, 2'b00);
        check("s1_neg_pulse", neg_edge, 2'b11);
        step();
        check("s1_neg_end", neg_edge, 2'b00);

        // 2: settle high, then bit_in[0] falls and stays low
        bit_in = 2'b11;
        steps(ACC + 1);
        check("s2_settled", bit_out, 2'b11);
        bit_in = 2'b10;
        for (int k = 1; k < ACC; k++) begin
            step();
            check("s2_hold", bit_out, 2'b11);
        end
        step();
        check("s2_fall", bit_out, 2'b10);
        check("s2_neg_pulse", neg_edge, 2'b01);
        check("s2_no_pos", pos_edge, 2'b00);
        step();
        check("s2_neg_end", neg_edge, 2'b00);

        // 3: short low glitches are rejected and each one restarts the count
        bit_in = 2'b11;
        steps(ACC + 1);
        for (int g = 0; g < 2; g++) begin
            bit_in = 2'b10;
            steps(CYCLES - 1);
            bit_in = 2'b11;
            for (int k = 0; k < ACC + 1; k++) begin
                step();
                check("s3_glitch_out", bit_out, 2'b11);
                check("s3_glitch_neg", neg_edge, 2'b00);
            end
        end

        // 4: bit_in[1] toggles every 2 cycles for 20 cycles
        for (int t = 0; t < 10; t++) begin
            bit_in[1] = ~bit_in[1];
            for (int k = 0; k < 2; k++) begin
                step();
                check("s4_out1", {1'b0, bit_out[1]}, 2'b01);
                check("s4_edges1", {pos_edge[1], neg_edge[1]}, 2'b00);
            end
        end

        // 5: settle at 0, then a clean 0->1 step on bit 0
        bit_in = 2'b00;
        steps(ACC + 1);
        check("s5_settled", bit_out, 2'b00);
        bit_in  = 2'b01;
        pos_cnt = 0;
        neg_cnt = 0;
        for (int k = 0; k < ACC + 3; k++) begin
            step();
            if (pos_edge[0]) pos_cnt++;
            if (neg_edge[0]) neg_cnt++;
        end
        check("s5_rise", bit_out, 2'b01);
        check("s5_pos_count", WIDTH'(pos_cnt), WIDTH'(1));
        check("s5_neg_count", WIDTH'(neg_cnt), WIDTH'(0));

        // 6: random slow activity with noise and occasional reset
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) bit_in[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        steps(ACC + 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
